// File: rtl/strength_pkg.sv
// rtl/strength_pkg.sv - shared strength levels, FSM states and widths for strength_bus_driver
package strength_pkg;

    localparam int STR_W = 2;

    typedef enum logic [1:0] {
        STR_HIZ,
        STR_WEAK,
        STR_STRONG,
        STR_SUPPLY
    } strength_e;

    typedef enum logic [1:0] {
        SBD_IDLE,
        SBD_ARB,
        SBD_DRIVE,
        SBD_TURN
    } sbd_state_e;

endpackage

// File: rtl/strength_resolve_bit.sv
// rtl/strength_resolve_bit.sv - combinational strength-precedence resolution of one bus bit
module strength_resolve_bit
    import strength_pkg::*;
#(
    parameter int N_SRC = 2
) (
    input  logic [N_SRC-1:0]       src_en,
    input  logic [N_SRC-1:0]       src_val,
    input  logic [N_SRC*STR_W-1:0] src_str,
    output logic                   val,
    output logic                   en,
    output logic                   conflict
);

    strength_e top_str;
    logic      any_one;
    logic      any_zero;

    always_comb begin
        top_str = STR_HIZ;
        for (int s = 0; s < N_SRC; s++) begin
            if (src_en[s] && (strength_e'(src_str[s*STR_W +: STR_W]) > top_str)) begin
                top_str = strength_e'(src_str[s*STR_W +: STR_W]);
            end
        end

        // Only sources sitting at the winning strength take part in the value vote.
        any_one  = 1'b0;
        any_zero = 1'b0;
        for (int s = 0; s < N_SRC; s++) begin
            if (src_en[s] && (top_str != STR_HIZ) &&
                (strength_e'(src_str[s*STR_W +: STR_W]) == top_str)) begin
                if (src_val[s]) begin
                    any_one = 1'b1;
                end else begin
                    any_zero = 1'b1;
                end
            end
        end

        val      = any_one & ~any_zero;
        en       = any_one ^ any_zero;
        conflict = any_one & any_zero;
    end

endmodule

// File: rtl/strength_bus_driver.sv
// rtl/strength_bus_driver.sv - arbitrated strength-resolved bus driver with hold/turnaround windows
// Optional sticky conflict flag and clear input under STRENGTH_BUS_STICKY_CONFLICT_EN.
module strength_bus_driver
    import strength_pkg::*;
#(
    parameter int           W         = 15,
    parameter int           N_SRC     = 2,
    parameter int           HOLD_CYC  = 4,
    parameter int           TURN_CYC  = 1,
    parameter logic [W-1:0] WEAK_DFLT = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_SRC-1:0]       req,
    input  logic [N_SRC*W-1:0]     req_val,
    input  logic [N_SRC*STR_W-1:0] req_str,
    output logic [N_SRC-1:0]       grant,
    output logic [W-1:0]           bus_val,
    output logic [W-1:0]           bus_en,
    output logic [W-1:0]           bus_conflict,
    output logic                   tap,
    output logic                   busy
`ifdef STRENGTH_BUS_STICKY_CONFLICT_EN
    ,
    input  logic                   conflict_clr,
    output logic                   sticky_conflict
`endif
);

    localparam int MAX_CYC = (HOLD_CYC > TURN_CYC) ? HOLD_CYC : TURN_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    sbd_state_e               state;
    logic [CNT_W-1:0]         cnt;
    logic [N_SRC-1:0]         cap_req;
    logic [N_SRC*W-1:0]       cap_val;
    logic [N_SRC*STR_W-1:0]   cap_str;
    logic [W-1:0]             res_val;
    logic [W-1:0]             res_en;
    logic [W-1:0]             res_conflict;

    for (genvar b = 0; b < W; b++) begin : g_bit
        logic [N_SRC-1:0] bit_val;
        for (genvar s = 0; s < N_SRC; s++) begin : g_src
            assign bit_val[s] = cap_val[s*W + b];
        end
        strength_resolve_bit #(
            .N_SRC(N_SRC)
        ) u_resolve (
            .src_en   (cap_req),
            .src_val  (bit_val),
            .src_str  (cap_str),
            .val      (res_val[b]),
            .en       (res_en[b]),
            .conflict (res_conflict[b])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= SBD_IDLE;
            cnt          <= '0;
            cap_req      <= '0;
            cap_val      <= '0;
            cap_str      <= '0;
            grant        <= '0;
            bus_val      <= WEAK_DFLT;
            bus_en       <= '0;
            bus_conflict <= '0;
        end else begin
            grant <= '0;
            case (state)
                SBD_IDLE: begin
                    if (|req) begin
                        cap_req <= req;
                        cap_val <= req_val;
                        cap_str <= req_str;
                        state   <= SBD_ARB;
                    end
                end
                SBD_ARB: begin
                    state        <= SBD_DRIVE;
                    cnt          <= CNT_W'(HOLD_CYC - 1);
                    grant        <= cap_req;
                    // Undriven and clashing bits fall back to the weak default.
                    bus_val      <= res_val | (WEAK_DFLT & ~res_en);
                    bus_en       <= res_en;
                    bus_conflict <= res_conflict;
                end
                SBD_DRIVE: begin
                    if (cnt == '0) begin
                        state        <= SBD_TURN;
                        cnt          <= CNT_W'(TURN_CYC - 1);
                        bus_val      <= WEAK_DFLT;
                        bus_en       <= '0;
                        bus_conflict <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                SBD_TURN: begin
                    if (cnt == '0) begin
                        state <= SBD_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= SBD_IDLE;
            endcase
        end
    end

    assign busy = (state != SBD_IDLE);
    assign tap  = bus_val[W-5];

`ifdef STRENGTH_BUS_STICKY_CONFLICT_EN
    // A fresh conflict outranks a simultaneous clear so no clash is ever lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_conflict <= 1'b0;
        end else if ((state == SBD_ARB) && (|res_conflict)) begin
            sticky_conflict <= 1'b1;
        end else if (conflict_clr) begin
            sticky_conflict <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_strength_bus_driver.sv
// tb/tb_strength_bus_driver.sv - randomized self-checking bench for strength_bus_driver
module tb_strength_bus_driver;

    localparam int           W    = 15;
    localparam int           N    = 2;
    localparam int           HOLD = 4;
    localparam int           TURN = 1;
    localparam logic [W-1:0] DFLT = 15'h2C41;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_val;
    logic [N*2-1:0]   req_str;
    logic [N-1:0]     grant;
    logic [W-1:0]     bus_val;
    logic [W-1:0]     bus_en;
    logic [W-1:0]     bus_conflict;
    logic             tap;
    logic             busy;
`ifdef STRENGTH_BUS_STICKY_CONFLICT_EN
    logic             conflict_clr;
    logic             sticky_conflict;
`endif

    logic [W-1:0] dflt = DFLT;
    int checks   = 0;
    int failures = 0;

    strength_bus_driver #(
        .W         (W),
        .N_SRC     (N),
        .HOLD_CYC  (HOLD),
        .TURN_CYC  (TURN),
        .WEAK_DFLT (DFLT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_val      (req_val),
        .req_str      (req_str),
        .grant        (grant),
        .bus_val      (bus_val),
        .bus_en       (bus_en),
        .bus_conflict (bus_conflict),
        .tap          (tap),
        .busy         (busy)
`ifdef STRENGTH_BUS_STICKY_CONFLICT_EN
        ,
        .conflict_clr    (conflict_clr),
        .sticky_conflict (sticky_conflict)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Per bit: strongest driving level wins; unanimous winners drive, split winners clash.
    function automatic void model(input logic [N-1:0] m, input logic [N*W-1:0] v,
                                  input logic [N*2-1:0] s, output logic [W-1:0] ev,
                                  output logic [W-1:0] ee, output logic [W-1:0] ec);
        for (int b = 0; b < W; b++) begin
            int best;
            int ones;
            int zeros;
            best  = 0;
            ones  = 0;
            zeros = 0;
            for (int k = 0; k < N; k++) begin
                int st;
                st = int'((s >> (2*k)) & 2'b11);
                if (m[k] && st > best) best = st;
            end
            for (int k = 0; k < N; k++) begin
                int st;
                st = int'((s >> (2*k)) & 2'b11);
                if (m[k] && best > 0 && st == best) begin
                    if (v[k*W + b]) ones++;
                    else zeros++;
                end
            end
            ee[b] = (best > 0) && (ones == 0 || zeros == 0);
            ec[b] = (ones > 0) && (zeros > 0);
            ev[b] = ee[b] ? (ones > 0) : dflt[b];
        end
    endfunction

    task automatic check_released(input string tag, input logic exp_busy);
        chk({tag, "_busy"}, busy, exp_busy);
        chk({tag, "_grant"}, grant, '0);
        chk({tag, "_en"}, bus_en, '0);
        chk({tag, "_cf"}, bus_conflict, '0);
        chk({tag, "_val"}, bus_val, dflt);
        chk({tag, "_tap"}, tap, dflt[W-5]);
    endtask

    task automatic scramble_inputs();
        req     = N'($urandom);
        req_val = {15'($urandom), 15'($urandom)};
        req_str = (N*2)'($urandom);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after it is idle again.
    task automatic run_txn(input string tag, input logic [N-1:0] m, input logic [N*W-1:0] v,
                           input logic [N*2-1:0] s, input bit scramble);
        logic [W-1:0] ev, ee, ec;
        model(m, v, s, ev, ee, ec);
        req     = m;
        req_val = v;
        req_str = s;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_arb_busy"}, busy, 1'b1);
        chk({tag, "_arb_en"}, bus_en, '0);
        for (int i = 0; i < HOLD + TURN; i++) begin
            if (scramble) scramble_inputs();
            else req = '0;
            @(posedge clk);
            @(negedge clk);
            if (i < HOLD) begin
                chk({tag, "_grant"}, grant, (i == 0) ? m : '0);
                chk({tag, "_val"}, bus_val, ev);
                chk({tag, "_en"}, bus_en, ee);
                chk({tag, "_cf"}, bus_conflict, ec);
                chk({tag, "_tap"}, tap, ev[W-5]);
                chk({tag, "_busy"}, busy, 1'b1);
            end else begin
                check_released({tag, "_turn"}, 1'b1);
            end
        end
        if (scramble) scramble_inputs();
        @(posedge clk);
        @(negedge clk);
        check_released({tag, "_idle"}, 1'b0);
    endtask

    initial begin
        clk     = 1'b0;
        rst_n   = 1'b0;
        req     = '0;
        req_val = '0;
        req_str = '0;
`ifdef STRENGTH_BUS_STICKY_CONFLICT_EN
        conflict_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_released("reset", 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_released("idle_noreq", 1'b0);

        run_txn("single_strong", 2'b01, {15'h0000, 15'h7FFF}, {2'd0, 2'd2}, 1'b0);
        run_txn("strong_weak",   2'b11, {15'h7FFF, 15'h0000}, {2'd2, 2'd1}, 1'b0);
        run_txn("clash",         2'b11, {15'h0000, 15'h0010}, {2'd2, 2'd2}, 1'b0);
        run_txn("all_hiz",       2'b11, {15'h1234, 15'h4321}, {2'd0, 2'd0}, 1'b0);
        run_txn("single_weak",   2'b10, {15'h5A5A, 15'h0000}, {2'd1, 2'd3}, 1'b0);
        run_txn("supply_strong", 2'b11, {15'h0F0F, 15'h70F0}, {2'd3, 2'd2}, 1'b0);

        // Back-to-back with live, changing inputs during DRIVE/TURN.
        for (int t = 0; t < 40; t++) begin
            run_txn("rand", N'($urandom_range(1, 3)), {15'($urandom), 15'($urandom)},
                    (N*2)'($urandom), 1'b1);
        end

        // Reset in the middle of DRIVE abandons the transaction.
        req     = 2'b11;
        req_val = {15'h7FFF, 15'h7FFF};
        req_str = {2'd2, 2'd2};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_drive_en", bus_en, 15'h7FFF);
        rst_n = 1'b0;
        req   = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_released("rst_mid", 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_released("rst_after", 1'b0);

`ifdef STRENGTH_BUS_STICKY_CONFLICT_EN
        conflict_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        conflict_clr = 1'b0;
        chk("sticky_pre", sticky_conflict, 1'b0);
        run_txn("s_clash", 2'b11, {15'h0000, 15'h0010}, {2'd2, 2'd2}, 1'b0);
        chk("sticky_set", sticky_conflict, 1'b1);
        run_txn("s_clean", 2'b01, {15'h0000, 15'h7FFF}, {2'd0, 2'd2}, 1'b0);
        chk("sticky_hold", sticky_conflict, 1'b1);
        conflict_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        conflict_clr = 1'b0;
        chk("sticky_clr", sticky_conflict, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
